// File: rtl/imem_loader.sv
// imem_loader: assembles a framed big-endian byte stream into 32-bit words and writes them to instruction memory, holding the CPU in reset until a complete valid program is loaded.
// Frame: LEN_HI, LEN_LO (word count N), 4*N data bytes MSB first, plus one XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
// Ports: clk/rst (async active-high); in_data/in_valid/in_ready byte stream; load_req restarts loading;
//   imem_we/imem_addr/imem_wdata registered memory write port; cpu_rst/done/err status; words_loaded write count.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        load_req,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);
  localparam int TW = $clog2(TIMEOUT + 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
  localparam state_t S_FIN = S_CHK;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERR} state_t;
  localparam state_t S_FIN = S_DONE;
`endif
  state_t state, state_n;
  logic [15:0] len, word_idx, n_rx;
  logic [1:0] byte_cnt;
  logic [23:0] shift;
  logic [TW-1:0] timer;
  logic xfer, timed, expire, last_word;
  assign in_ready = state != S_DONE && state != S_ERR;
  assign done = state == S_DONE;
  assign err = state == S_ERR;
  assign cpu_rst = !done;
  assign xfer = in_valid && in_ready;
  assign n_rx = {len[15:8], in_data};
  assign last_word = word_idx == len - 16'd1;
  assign timed = in_ready && state != S_LEN_HI;
  // idle cycles are counted from the last transfer or state entry; the TIMEOUT-th idle cycle aborts
  assign expire = timed && !xfer && timer == TW'(TIMEOUT - 1);
  always_comb begin
    state_n = state;
    if (load_req) state_n = S_LEN_HI;
    else if (expire) state_n = S_ERR;
    else if (xfer && state == S_LEN_HI) state_n = S_LEN_LO;
    else if (xfer && state == S_LEN_LO) state_n = n_rx > 16'(DEPTH) ? S_ERR : n_rx == 16'd0 ? S_FIN : S_DATA;
    else if (xfer && state == S_DATA && byte_cnt == 2'd3 && last_word) state_n = S_FIN;
`ifdef IMEM_LOADER_CHECKSUM_EN
    else if (xfer && state == S_CHK) state_n = in_data == csum ? S_DONE : S_ERR;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LEN_HI;
      len <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      shift <= '0;
      timer <= '0;
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
      words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      state <= state_n;
      imem_we <= 1'b0;
      timer <= (load_req || xfer || state_n != state) ? '0 : timer + TW'(timed);
      if (load_req) words_loaded <= '0;
      else if (xfer) begin
        if (state == S_LEN_HI) len[15:8] <= in_data;
        if (state == S_LEN_LO) begin
          len[7:0] <= in_data;
          word_idx <= '0;
          byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum <= '0;
`endif
        end
        if (state == S_DATA) begin
          shift <= {shift[15:0], in_data};
          byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum <= csum ^ in_data;
`endif
          if (byte_cnt == 2'd3) begin
            imem_we <= 1'b1;
            imem_addr <= {14'd0, word_idx, 2'd0};
            imem_wdata <= {shift, in_data};
            word_idx <= word_idx + 16'd1;
            if (words_loaded != 16'(DEPTH)) words_loaded <= words_loaded + 16'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random and directed frames checked against a frame-level model of expected writes and outcome.
module tb_imem_loader;
  localparam int DEPTH = 64;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, load_req = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, imem_we, cpu_rst, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] words_loaded;
  int n_cmp = 0, n_bad = 0, stalls = 0;
  logic [7:0] frame[$];
  logic [63:0] got[$], exp_q[$];

  imem_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .load_req(load_req), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (imem_we) got.push_back({imem_addr, imem_wdata});

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, in_ready, 1);
    chk({tag, "_cpurst"}, cpu_rst, 1);
    chk({tag, "_we"}, imem_we, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_words"}, words_loaded, 0);
  endtask

  task automatic pulse_load(input bit with_byte, input logic [7:0] b);
    @(negedge clk);
    load_req = 1'b1;
    in_valid = with_byte;
    in_data = b;
    @(negedge clk);
    load_req = 1'b0;
    in_valid = 1'b0;
    chk("ld_ready", in_ready, 1);
    chk("ld_err", err, 0);
    chk("ld_done", done, 0);
    chk("ld_cpurst", cpu_rst, 1);
    chk("ld_words", words_loaded, 0);
    got.delete();
  endtask

  task automatic send(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      in_data = 8'($urandom);
    end
    @(negedge clk);
    if (!in_ready) stalls++;
    in_valid = 1'b1;
    in_data = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic make_frame(input int n, input bit good);
    logic [7:0] x, b;
    frame.delete();
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    if (n <= DEPTH) begin
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        x = x ^ b;
        frame.push_back(b);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      frame.push_back(good ? x : x ^ 8'($urandom_range(1, 255)));
`endif
    end
  endtask

  task automatic run_frame(input string tag, input bit drop);
    int n;
    logic [7:0] x;
    logic [31:0] d;
    bit ok;
    n = int'({frame[0], frame[1]});
    exp_q.delete();
    x = 8'h00;
    ok = n <= DEPTH;
    if (ok) begin
      for (int w = 0; w < n; w++) begin
        d = {frame[2 + 4 * w], frame[3 + 4 * w], frame[4 + 4 * w], frame[5 + 4 * w]};
        x = x ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
        exp_q.push_back({32'(w * 4), d});
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ok = frame[2 + 4 * n] == x;
`endif
    end
    pulse_load(drop, 8'h00);
    stalls = 0;
    foreach (frame[i]) send(frame[i]);
    @(negedge clk);
    chk({tag, "_done"}, done, ok);
    chk({tag, "_err"}, err, !ok);
    chk({tag, "_cpurst"}, cpu_rst, !ok);
    chk({tag, "_words"}, words_loaded, exp_q.size());
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (exp_q.size() > 0) chk({tag, "_we_last"}, imem_we, 1);
`endif
    repeat (2) @(negedge clk);
    chk({tag, "_done_hold"}, done, ok);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_stalls"}, stalls, 0);
    chk({tag, "_nwr"}, got.size(), exp_q.size());
    foreach (exp_q[i]) if (i < got.size()) chk({tag, "_wr"}, got[i], exp_q[i]);
  endtask

  initial begin
    int r, n, c;
    repeat (2) @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;
    frame = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    frame.push_back(8'h89);
`endif
    run_frame("tp2", 1'b0);
    if (got.size() == 2) begin
      chk("tp2_w0", got[0], {32'h0, 32'h20080005});
      chk("tp2_w1", got[1], {32'h4, 32'hAC080000});
    end
    frame = {8'h00, 8'h41};
    run_frame("big", 1'b0);
    frame = {8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    frame.push_back(8'h00);
`endif
    run_frame("len0", 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    frame = {8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    run_frame("ck_ok", 1'b0);
    frame = {8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_frame("ck_bad", 1'b0);
    if (got.size() == 1) chk("ck_bad_w0", got[0], {32'h0, 32'h01020304});
`endif
    make_frame(1, 1'b1);
    run_frame("drop", 1'b1);
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      n = r == 0 ? $urandom_range(DEPTH + 1, 300) : r == 1 ? DEPTH : $urandom_range(0, 6);
      make_frame(n, $urandom_range(0, 3) != 0);
      run_frame("rnd", 1'($urandom_range(0, 1)));
    end
    pulse_load(1'b0, 8'h00);
    send(8'h00);
    send(8'h01);
    send(8'h12);
    send(8'h34);
    repeat (TIMEOUT - 2) @(negedge clk);
    chk("to_early", err, 0);
    c = 0;
    while (!err && c < 8) begin
      @(negedge clk);
      c++;
    end
    chk("to_err", err, 1);
    chk("to_cpurst", cpu_rst, 1);
    chk("to_ready", in_ready, 0);
    chk("to_nwr", got.size(), 0);
    pulse_load(1'b0, 8'h00);
    send(8'h00);
    send(8'h01);
    send(8'hDE);
    send(8'hAD);
    send(8'hBE);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("amid");
    @(negedge clk);
    rst = 1'b0;
    frame = {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef IMEM_LOADER_CHECKSUM_EN
    frame.push_back(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
`endif
    run_frame("post_rst", 1'b0);
    if (got.size() == 1) chk("post_rst_w0", got[0], {32'h0, 32'hDEADBEEF});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
